// File: rtl/montador_linha_pkg.sv
// Shared widths for the cache-line assembler and its output queue.
package pacote_hardcore;

   localparam int LARGURA_PALAVRA = 64;
   localparam int LARGURA_LINHA   = 512;
   localparam int TAM_ENDERECO    = 2;
   localparam int BATIDAS         = LARGURA_LINHA / LARGURA_PALAVRA;

   // A single-beat line still needs a 1-bit counter so the ports stay legal.
   function automatic int largura_contador(input int batidas);
      return (batidas > 1) ? $clog2(batidas) : 1;
   endfunction

   localparam int LARG_CONTADOR = largura_contador(BATIDAS);

endpackage

// File: rtl/montador_linha_fifo.sv
// Two-entry line+tag queue; entry 0 is always the head, so the head only
// changes on a pop or on a push into an empty queue.
module fifo_linhas #(
   parameter int LARGURA_LINHA = pacote_hardcore::LARGURA_LINHA,
   parameter int TAM_ENDERECO  = pacote_hardcore::TAM_ENDERECO
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [LARGURA_LINHA-1:0] i_linha,
   input  logic [TAM_ENDERECO-1:0]  i_tag,
   input  logic                     i_pop,
   output logic [LARGURA_LINHA-1:0] o_linha,
   output logic [TAM_ENDERECO-1:0]  o_tag,
   output logic                     o_valida,
   output logic [1:0]               o_ocupacao
);

   logic [LARGURA_LINHA-1:0] r_linha [0:1];
   logic [TAM_ENDERECO-1:0]  r_tag   [0:1];
   logic [1:0]               r_ocup;

   logic w_push;
   logic w_pop;

   assign w_pop  = i_pop && (r_ocup != 2'd0);
   assign w_push = i_push && ((r_ocup != 2'd2) || w_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ocup <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_linha[i] <= '0;
            r_tag[i]   <= '0;
         end
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_ocup == 2'd0) begin
                  r_linha[0] <= i_linha;
                  r_tag[0]   <= i_tag;
               end else begin
                  r_linha[1] <= i_linha;
                  r_tag[1]   <= i_tag;
               end
               r_ocup <= r_ocup + 2'd1;
            end
            2'b01: begin
               r_linha[0] <= r_linha[1];
               r_tag[0]   <= r_tag[1];
               r_ocup     <= r_ocup - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged: shift the tail forward when full.
               if (r_ocup == 2'd2) begin
                  r_linha[0] <= r_linha[1];
                  r_tag[0]   <= r_tag[1];
                  r_linha[1] <= i_linha;
                  r_tag[1]   <= i_tag;
               end else begin
                  r_linha[0] <= i_linha;
                  r_tag[0]   <= i_tag;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_linha    = r_linha[0];
   assign o_tag      = r_tag[0];
   assign o_valida   = (r_ocup != 2'd0);
   assign o_ocupacao = r_ocup;

endmodule

// File: rtl/montador_linha.sv
// Assembles BATIDAS beats into one cache line and queues it for the consumer.
// Optional sticky tag-mismatch flag under macro ERRO_ENDERECO_EN.
module montador_linha
   import pacote_hardcore::largura_contador;
#(
   parameter int LARGURA_PALAVRA = pacote_hardcore::LARGURA_PALAVRA,
   parameter int LARGURA_LINHA   = pacote_hardcore::LARGURA_LINHA,
   parameter int TAM_ENDERECO    = pacote_hardcore::TAM_ENDERECO
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [LARGURA_PALAVRA-1:0] palavra_in,
   input  logic [TAM_ENDERECO-1:0]    endereco_in,
   input  logic                       valida_in,
   output logic                       pronto_out,
   output logic [LARGURA_LINHA-1:0]   linha_cache,
   output logic [TAM_ENDERECO-1:0]    endereco,
   output logic                       linha_valida,
   input  logic                       consumidor_pronto
`ifdef ERRO_ENDERECO_EN
   ,
   output logic                       erro_endereco
`endif
);

   localparam int N_BATIDAS = LARGURA_LINHA / LARGURA_PALAVRA;
   localparam int LC        = largura_contador(N_BATIDAS);
   localparam logic [LC-1:0] ULTIMA = LC'(N_BATIDAS - 1);

   logic [LC-1:0]            r_cont;
   logic [LARGURA_LINHA-1:0] r_linha;
   logic [TAM_ENDERECO-1:0]  r_tag;

   logic                     w_aceita;
   logic                     w_ultima;
   logic                     w_push;
   logic                     w_pop;
   logic [TAM_ENDERECO-1:0]  w_tag;
   logic [LARGURA_LINHA-1:0] w_linha;
   logic [1:0]               w_ocup;

   assign w_ultima   = (r_cont == ULTIMA);
   // Only registered state feeds ready, so a same-cycle pop cannot open it.
   assign pronto_out = !((w_ocup == 2'd2) && w_ultima);
   assign w_aceita   = valida_in && pronto_out;
   assign w_push     = w_aceita && w_ultima;
   assign w_pop      = linha_valida && consumidor_pronto;
   assign w_tag      = (r_cont == '0) ? endereco_in : r_tag;

   for (genvar gi = 0; gi < N_BATIDAS; gi++) begin : g_fatia
      assign w_linha[gi*LARGURA_PALAVRA +: LARGURA_PALAVRA] =
         (r_cont == LC'(gi)) ? palavra_in
                             : r_linha[gi*LARGURA_PALAVRA +: LARGURA_PALAVRA];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cont  <= '0;
         r_linha <= '0;
         r_tag   <= '0;
      end else if (w_aceita) begin
         r_linha <= w_linha;
         if (r_cont == '0)
            r_tag <= endereco_in;
         r_cont <= w_ultima ? '0 : r_cont + 1'b1;
      end
   end

   fifo_linhas #(
      .LARGURA_LINHA (LARGURA_LINHA),
      .TAM_ENDERECO  (TAM_ENDERECO)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_push),
      .i_linha    (w_linha),
      .i_tag      (w_tag),
      .i_pop      (w_pop),
      .o_linha    (linha_cache),
      .o_tag      (endereco),
      .o_valida   (linha_valida),
      .o_ocupacao (w_ocup)
   );

`ifdef ERRO_ENDERECO_EN
   logic r_erro;

   always_ff @(posedge clk) begin
      if (reset)
         r_erro <= 1'b0;
      else if (w_aceita && (r_cont != '0) && (endereco_in != r_tag))
         r_erro <= 1'b1;
   end

   assign erro_endereco = r_erro;
`endif

endmodule

// File: tb/tb_montador_linha.sv
// Randomized and directed checks of montador_linha against a queue-based line model.
module tb_montador_linha;
   import pacote_hardcore::*;

   localparam int W = LARGURA_PALAVRA;
   localparam int L = LARGURA_LINHA;
   localparam int T = TAM_ENDERECO;
   localparam int B = BATIDAS;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [W-1:0]  palavra_in = '0;
   logic [T-1:0]  endereco_in = '0;
   logic          valida_in = 1'b0;
   logic          pronto_out;
   logic [L-1:0]  linha_cache;
   logic [T-1:0]  endereco;
   logic          linha_valida;
   logic          consumidor_pronto = 1'b0;
`ifdef ERRO_ENDERECO_EN
   logic          erro_endereco;
`endif

   montador_linha dut (
      .clk               (clk),
      .reset             (reset),
      .palavra_in        (palavra_in),
      .endereco_in       (endereco_in),
      .valida_in         (valida_in),
      .pronto_out        (pronto_out),
      .linha_cache       (linha_cache),
      .endereco          (endereco),
      .linha_valida      (linha_valida),
      .consumidor_pronto (consumidor_pronto)
`ifdef ERRO_ENDERECO_EN
      ,
      .erro_endereco     (erro_endereco)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [L-1:0] linha;
      logic [T-1:0] tag;
   } entrada_t;

   entrada_t     m_fila[$];
   int           m_cont = 0;
   logic [L-1:0] m_parcial = '0;
   logic [T-1:0] m_tag = '0;
   bit           m_erro = 0;
   int           n_checks = 0;
   int           n_errors = 0;

   task automatic verifica(input string nome, input logic [L-1:0] obs, input logic [L-1:0] esp);
      n_checks++;
      if (obs !== esp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nome, obs, esp);
      end
   endtask

   task automatic checa_saidas();
      bit esp_pronto;
      esp_pronto = !(m_fila.size() == 2 && m_cont == B - 1);
      verifica("linha_valida", L'(linha_valida), L'(m_fila.size() > 0));
      verifica("pronto_out", L'(pronto_out), L'(esp_pronto));
      if (m_fila.size() > 0) begin
         verifica("linha_cache", linha_cache, m_fila[0].linha);
         verifica("endereco", L'(endereco), L'(m_fila[0].tag));
      end
`ifdef ERRO_ENDERECO_EN
      verifica("erro_endereco", L'(erro_endereco), L'(m_erro));
`endif
   endtask

   // One clock: drive inputs, let the model react at the edge, check on the falling edge.
   task automatic passo(input bit v, input logic [W-1:0] p, input logic [T-1:0] e,
                        input bit c, input bit r);
      bit           pr;
      bit           aceita;
      bit           pop;
      logic [L-1:0] cheia;
      valida_in = v; palavra_in = p; endereco_in = e; consumidor_pronto = c; reset = r;
      @(posedge clk);
      if (r) begin
         m_fila.delete(); m_cont = 0; m_parcial = '0; m_erro = 0;
      end else begin
         pr     = !(m_fila.size() == 2 && m_cont == B - 1);
         aceita = v && pr;
         pop    = (m_fila.size() > 0) && c;
         cheia  = m_parcial;
         if (aceita) begin
            cheia[W*m_cont +: W] = p;
            if (m_cont == 0) m_tag = e;
            else if (e != m_tag) m_erro = 1;
         end
         if (pop) begin
            $display("pop line tag=%0d beat0=%0h", m_fila[0].tag, m_fila[0].linha[W-1:0]);
            void'(m_fila.pop_front());
         end
         if (aceita) begin
            if (m_cont == B - 1) begin
               m_fila.push_back('{cheia, m_tag});
               m_cont = 0; m_parcial = '0;
            end else begin
               m_parcial = cheia; m_cont++;
            end
         end
      end
      @(negedge clk);
      checa_saidas();
      if (r) begin
         verifica("reset_linha_cache", linha_cache, '0);
         verifica("reset_endereco", L'(endereco), '0);
      end
   endtask

   initial begin
      logic [W-1:0] pal;
      logic [T-1:0] tg;
      int           p_val;
      int           p_cons;

      passo(0, '0, '0, 0, 1);
      passo(1, 64'h55, 2'd1, 1, 1);

      // Line 0..7, tag 2, consumer ready.
      for (int i = 0; i < B; i++) passo(1, W'(i), 2'd2, 1, 0);
      verifica("r031_valida", L'(linha_valida), L'(1));
      verifica("r031_beat0", L'(linha_cache[W-1:0]), L'(0));
      verifica("r031_beat7", L'(linha_cache[L-1 -: W]), L'(7));
      verifica("r031_tag", L'(endereco), L'(2));
      passo(0, '0, '0, 1, 0);

      // Three lines with consumer stalled; third line stalls on its last beat.
      for (int i = 0; i < 3 * B - 1; i++)
         passo(1, W'(64'h1000 + i), T'(i / B + 1), 0, 0);
      verifica("r032_pronto0", L'(pronto_out), L'(0));
      passo(1, W'(64'h1000 + 3 * B - 1), 2'd3, 0, 0);
      passo(1, W'(64'h1000 + 3 * B - 1), 2'd3, 0, 0);
      verifica("r032_tag1", L'(endereco), L'(1));
      passo(1, W'(64'h1000 + 3 * B - 1), 2'd3, 1, 0);
      verifica("r033_tag2", L'(endereco), L'(2));
      verifica("r033_pronto1", L'(pronto_out), L'(1));
      passo(1, W'(64'h1000 + 3 * B - 1), 2'd3, 0, 0);
      verifica("r033_hold_tag2", L'(endereco), L'(2));
      passo(0, '0, '0, 1, 0);
      verifica("r032_tag3", L'(endereco), L'(3));
      verifica("r032_last_beat", L'(linha_cache[L-1 -: W]), L'(64'h1000 + 3 * B - 1));
      passo(0, '0, '0, 1, 0);
      verifica("r032_empty", L'(linha_valida), L'(0));

      // Reset mid-line with one queued line.
      for (int i = 0; i < B + 5; i++) passo(1, W'(64'h2000 + i), 2'd1, 0, 0);
      passo(1, 64'hdead, 2'd1, 1, 1);
      verifica("r034_valida0", L'(linha_valida), L'(0));
      for (int i = 0; i < B; i++) passo(1, W'(64'h100 + i), 2'd2, 0, 0);
      verifica("r034_beat0", L'(linha_cache[W-1:0]), L'(64'h100));
      passo(0, '0, '0, 1, 0);

      // Valid toggling every cycle across 16 beats.
      for (int i = 0; i < 4 * B; i++) passo(i % 2 == 0, W'(64'h3000 + i), 2'd0, 0, 0);
      verifica("r036_valida", L'(linha_valida), L'(1));
      verifica("r036_beat0", L'(linha_cache[W-1:0]), L'(64'h3000));
      passo(0, '0, '0, 1, 0);
      verifica("r036_line2_beat0", L'(linha_cache[W-1:0]), L'(64'h3000 + 2 * B));
      passo(0, '0, '0, 1, 0);

`ifdef ERRO_ENDERECO_EN
      passo(0, '0, '0, 0, 1);
      for (int i = 0; i < B; i++) passo(1, W'(i), (i == 5) ? 2'd3 : 2'd1, 0, 0);
      verifica("r035_erro", L'(erro_endereco), L'(1));
      verifica("r035_tag", L'(endereco), L'(1));
      passo(0, '0, '0, 1, 0);
      verifica("r035_sticky", L'(erro_endereco), L'(1));
      passo(0, '0, '0, 0, 1);
      verifica("r035_clear", L'(erro_endereco), L'(0));
`endif

      // Random traffic with varying source/consumer duty and rare resets.
      for (int i = 0; i < 3000; i++) begin
         p_val  = 20 + 20 * ((i / 500) % 4);
         p_cons = 80 - 20 * ((i / 500) % 4);
         pal = {$urandom, $urandom};
         if (m_cont == 0 || $urandom_range(0, 49) == 0) tg = T'($urandom);
         else tg = m_tag;
         passo($urandom_range(0, 99) < p_val, pal, tg,
               $urandom_range(0, 99) < p_cons, $urandom_range(0, 299) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/montador_linha.md
MONTADOR_LINHA -- requirements
Module: montador_linha

Interface
REQ-001 Parameter LARGURA_PALAVRA, default 64, SHALL be the input beat width in bits.
REQ-002 Parameter LARGURA_LINHA, default 512, SHALL be the assembled cache-line width in bits; it SHALL be an integer multiple of LARGURA_PALAVRA.
REQ-003 Parameter TAM_ENDERECO, default 2, SHALL be the page-address tag width.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 palavra_in  input  LARGURA_PALAVRA  SHALL carry one beat of line data.
REQ-007 endereco_in  input  TAM_ENDERECO  SHALL carry the page tag for the line.
REQ-008 valida_in  input  1  SHALL indicate that the beat is valid.
REQ-009 pronto_out  output  1  SHALL indicate that a beat can be accepted.
REQ-010 linha_cache  output  LARGURA_LINHA  SHALL carry the assembled line at the FIFO head.
REQ-011 endereco  output  TAM_ENDERECO  SHALL carry the tag of the FIFO-head line.
REQ-012 linha_valida  output  1  SHALL indicate that the FIFO head holds a valid line.
REQ-013 consumidor_pronto  input  1  SHALL indicate that the downstream stage takes the FIFO-head line.
REQ-014 erro_endereco  output  1  SHALL be a sticky tag-mismatch flag, present only under ERRO_ENDERECO_EN.

Function
REQ-015 A beat SHALL be accepted iff valida_in && pronto_out at the rising edge.
REQ-016 BATIDAS = LARGURA_LINHA/LARGURA_PALAVRA; a counter SHALL run 0..BATIDAS-1, incrementing on each accepted beat and wrapping to 0 after the last beat.
REQ-017 Beat k SHALL be stored in line bits [LARGURA_PALAVRA*k +: LARGURA_PALAVRA], with beat 0 in the least significant bits.
REQ-018 endereco_in SHALL be captured on beat 0 only; its value on beats 1..BATIDAS-1 SHALL be ignored for the data path.
REQ-019 On acceptance of beat BATIDAS-1, the completed line and its tag SHALL be pushed into a 2-entry FIFO; linha_valida SHALL be high from the next cycle when the FIFO was empty (latency 1 cycle).
REQ-020 A pop SHALL occur iff linha_valida && consumidor_pronto; lines SHALL leave in arrival order.
REQ-021 A simultaneous push and pop SHALL leave the occupancy unchanged and SHALL lose no line.
REQ-022 pronto_out SHALL be 0 only when the FIFO holds 2 lines and the counter equals BATIDAS-1; it SHALL NOT depend combinationally on consumidor_pronto.
REQ-023 When the FIFO is full, beats 0..BATIDAS-2 SHALL still be accepted.
REQ-024 linha_cache and endereco SHALL hold stable while linha_valida=1 and no pop occurs.

Reset
REQ-025 reset SHALL clear the beat counter, FIFO occupancy, linha_valida, linha_cache, endereco and erro_endereco to 0, and SHALL set pronto_out to 1 in the following cycle.
REQ-026 reset asserted mid-line or with the FIFO occupied SHALL discard the partial line and all queued lines; reset SHALL take priority over any simultaneous beat or pop.

Configuration
REQ-027 Macro ERRO_ENDERECO_EN defined: erro_endereco SHALL rise the cycle after an accepted beat 1..BATIDAS-1 whose endereco_in differs from the captured tag, and SHALL stay high until reset.
REQ-028 Macro ERRO_ENDERECO_EN undefined: the port and its comparison logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 A shared package pacote_hardcore SHALL hold LARGURA_PALAVRA, LARGURA_LINHA, TAM_ENDERECO and the derived BATIDAS constants.
REQ-030 The 2-entry line+tag queue SHALL be a sub-module fifo_linhas; beat counting and assembly SHALL reside in montador_linha.

Verification
REQ-031 Reset, then 8 beats 64'h0..64'h7 with endereco_in=2 and consumidor_pronto=1 -> the cycle after beat 7: linha_valida=1, linha_cache[63:0]=0, linha_cache[511:448]=7, endereco=2.
REQ-032 consumidor_pronto=0, stream 3 lines (24 beats) -> after line 2, pronto_out=0 at counter 7 of line 3; raise consumidor_pronto -> lines pop in order 1,2,3 with none lost.
REQ-033 Full FIFO with a pop and the last beat in the same cycle -> pronto_out stays 0 that cycle; the beat is accepted the next cycle; occupancy never exceeds 2.
REQ-034 reset asserted after beat 4 of a line with 1 queued line -> linha_valida=0; the next 8 beats form a fresh line with beat 0 in bits [63:0].
REQ-035 ERRO_ENDERECO_EN defined, tag 1 on beat 0 and tag 3 on beat 5 -> erro_endereco=1 from the next cycle until reset; endereco output=1.
REQ-036 valida_in toggled 1,0,1,0 across 16 beats -> 2 lines are assembled, with gap cycles not advancing the counter.
